// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: evaluates conditional branches, checks the
// fetch prediction, drives redirect/flush and returns training feedback.
module branch_resolver #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              ex_valid_in,
    input  logic              ex_is_branch_in,
    input  logic [2:0]        ex_funct3_in,
    input  logic [XLEN-1:0]   ex_pc_in,
    input  logic [XLEN-1:0]   ex_imm_in,
    input  logic [XLEN-1:0]   rs1_val_in,
    input  logic [XLEN-1:0]   rs2_val_in,
    input  logic              ex_pred_taken_in,
    input  logic [XLEN-1:0]   ex_pred_target_in,
    input  logic              interrupt_signal_in,
    output logic              redirect_out,
    output logic [XLEN-1:0]   redirect_pc_out,
    output logic              flush_out,
    output logic              branch_jump_signal_out,
    output logic [2:0]        branch_type_signal_out,
    output logic              update_valid_out,
    output logic [CNT_W-1:0]  branch_count_out,
    output logic [CNT_W-1:0]  mispredict_count_out
);

    localparam int unsigned FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t           r_state;
    logic [FCW-1:0]   r_fcnt;
    logic             r_redirect;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             r_flush;
    logic             r_jump;
    logic [2:0]       r_type;
    logic             r_update;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    logic             w_eq;
    logic             w_lt;
    logic             w_ltu;
    logic             w_taken;
    logic             w_legal;
    logic             w_resolve;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_mispredict;

    assign w_eq      = (rs1_val_in == rs2_val_in);
    assign w_lt      = ($signed(rs1_val_in) < $signed(rs2_val_in));
    assign w_ltu     = (rs1_val_in < rs2_val_in);
    // funct3 010/011 are not conditional branches
    assign w_legal   = ex_funct3_in[2] | ~ex_funct3_in[1];
    assign w_resolve = ex_valid_in & ex_is_branch_in & w_legal
                     & (r_state == S_IDLE) & ~interrupt_signal_in;
    assign w_target  = ex_pc_in + ex_imm_in;
    assign w_next_pc = w_taken ? w_target : (ex_pc_in + XLEN'(4));
    // predicted target only matters when the branch was predicted taken
    assign w_mispredict = (w_taken != ex_pred_taken_in)
                        | (w_taken & (ex_pred_target_in != w_target));

    always_comb begin
        w_taken = 1'b0;
        case (ex_funct3_in)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = ~w_eq;
            3'b100:  w_taken = w_lt;
            3'b101:  w_taken = ~w_lt;
            3'b110:  w_taken = w_ltu;
            3'b111:  w_taken = ~w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= S_IDLE;
            r_fcnt        <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_flush       <= 1'b0;
            r_jump        <= 1'b0;
            r_type        <= 3'b000;
            r_update      <= 1'b0;
            r_br_cnt      <= '0;
            r_mis_cnt     <= '0;
        end else begin
            r_redirect <= 1'b0;
            r_update   <= 1'b0;
            r_jump     <= 1'b0;
            if (interrupt_signal_in) begin
                r_state <= S_IDLE;
                r_fcnt  <= '0;
                r_flush <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_resolve) begin
                            r_update <= 1'b1;
                            r_jump   <= w_taken;
                            r_type   <= {ex_funct3_in[1], ex_funct3_in[2], ex_funct3_in[0]};
                            if (r_br_cnt != {CNT_W{1'b1}})
                                r_br_cnt <= r_br_cnt + CNT_W'(1);
                            if (w_mispredict) begin
                                if (r_mis_cnt != {CNT_W{1'b1}})
                                    r_mis_cnt <= r_mis_cnt + CNT_W'(1);
                                r_redirect    <= 1'b1;
                                r_redirect_pc <= w_next_pc;
                                r_flush       <= 1'b1;
                                r_fcnt        <= FCW'(FLUSH_CYCLES - 1);
                                r_state       <= S_FLUSH;
                            end
                        end
                    end
                    S_FLUSH: begin
                        // flush stays high through the cycle the counter reads zero
                        if (r_fcnt == '0) begin
                            r_state <= S_IDLE;
                            r_flush <= 1'b0;
                        end else begin
                            r_fcnt <= r_fcnt - FCW'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign redirect_out           = r_redirect;
    assign redirect_pc_out        = r_redirect_pc;
    assign flush_out              = r_flush;
    assign branch_jump_signal_out = r_jump;
    assign branch_type_signal_out = r_type;
    assign update_valid_out       = r_update;
    assign branch_count_out       = r_br_cnt;
    assign mispredict_count_out   = r_mis_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed test-plan steps plus random branches,
// checked each cycle against a behavioural model (default and 4-bit-counter builds).
module tb_branch_resolver;

    localparam int unsigned XLEN = 64;
    localparam int unsigned FC   = 2;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            ex_valid_in;
    logic            ex_is_branch_in;
    logic [2:0]      ex_funct3_in;
    logic [XLEN-1:0] ex_pc_in;
    logic [XLEN-1:0] ex_imm_in;
    logic [XLEN-1:0] rs1_val_in;
    logic [XLEN-1:0] rs2_val_in;
    logic            ex_pred_taken_in;
    logic [XLEN-1:0] ex_pred_target_in;
    logic            interrupt_signal_in;

    logic            redirect_out, flush_out, jump_out, upd_out;
    logic [XLEN-1:0] redirect_pc_out;
    logic [2:0]      type_out;
    logic [31:0]     bcnt_out, mcnt_out;

    logic            s_redirect, s_flush, s_jump, s_upd;
    logic [XLEN-1:0] s_redirect_pc;
    logic [2:0]      s_type;
    logic [3:0]      s_bcnt, s_mcnt;

    always #5 clk_in = ~clk_in;

    branch_resolver #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(32)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .ex_valid_in(ex_valid_in),
        .ex_is_branch_in(ex_is_branch_in), .ex_funct3_in(ex_funct3_in),
        .ex_pc_in(ex_pc_in), .ex_imm_in(ex_imm_in), .rs1_val_in(rs1_val_in),
        .rs2_val_in(rs2_val_in), .ex_pred_taken_in(ex_pred_taken_in),
        .ex_pred_target_in(ex_pred_target_in), .interrupt_signal_in(interrupt_signal_in),
        .redirect_out(redirect_out), .redirect_pc_out(redirect_pc_out),
        .flush_out(flush_out), .branch_jump_signal_out(jump_out),
        .branch_type_signal_out(type_out), .update_valid_out(upd_out),
        .branch_count_out(bcnt_out), .mispredict_count_out(mcnt_out));

    branch_resolver #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(4)) u_sat (
        .clk_in(clk_in), .rst_in(rst_in), .ex_valid_in(ex_valid_in),
        .ex_is_branch_in(ex_is_branch_in), .ex_funct3_in(ex_funct3_in),
        .ex_pc_in(ex_pc_in), .ex_imm_in(ex_imm_in), .rs1_val_in(rs1_val_in),
        .rs2_val_in(rs2_val_in), .ex_pred_taken_in(ex_pred_taken_in),
        .ex_pred_target_in(ex_pred_target_in), .interrupt_signal_in(interrupt_signal_in),
        .redirect_out(s_redirect), .redirect_pc_out(s_redirect_pc),
        .flush_out(s_flush), .branch_jump_signal_out(s_jump),
        .branch_type_signal_out(s_type), .update_valid_out(s_upd),
        .branch_count_out(s_bcnt), .mispredict_count_out(s_mcnt));

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // reference model state
    int unsigned     m_left;
    longint unsigned m_b32, m_m32, m_b4, m_m4;
    logic            e_redirect, e_flush, e_jump, e_upd;
    logic [XLEN-1:0] e_rpc;
    logic [2:0]      e_type;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned sat_inc(input longint unsigned v, input longint unsigned max);
        return (v >= max) ? max : v + 1;
    endfunction

    // Expected outputs for the next cycle, from the rules applied to current inputs
    task automatic model_step();
        logic            taken, legal, res, mis;
        logic [XLEN-1:0] tgt;
        int unsigned     nl;
        if (rst_in) begin
            m_left = 0; m_b32 = 0; m_m32 = 0; m_b4 = 0; m_m4 = 0;
            e_redirect = 0; e_flush = 0; e_jump = 0; e_upd = 0; e_rpc = '0; e_type = 3'b000;
            return;
        end
        e_redirect = 0; e_jump = 0; e_upd = 0;
        case (ex_funct3_in)
            3'd0:    taken = (rs1_val_in == rs2_val_in);
            3'd1:    taken = (rs1_val_in != rs2_val_in);
            3'd4:    taken = ($signed(rs1_val_in) <  $signed(rs2_val_in));
            3'd5:    taken = ($signed(rs1_val_in) >= $signed(rs2_val_in));
            3'd6:    taken = (rs1_val_in <  rs2_val_in);
            3'd7:    taken = (rs1_val_in >= rs2_val_in);
            default: taken = 0;
        endcase
        legal = !(ex_funct3_in == 3'd2 || ex_funct3_in == 3'd3);
        res   = ex_valid_in && ex_is_branch_in && legal && (m_left == 0) && !interrupt_signal_in;
        tgt   = ex_pc_in + ex_imm_in;
        mis   = (taken != ex_pred_taken_in) || (taken && ex_pred_target_in != tgt);
        if (interrupt_signal_in)  nl = 0;
        else if (m_left > 0)      nl = m_left - 1;
        else if (res && mis)      nl = FC;
        else                      nl = 0;
        if (res) begin
            e_upd  = 1;
            e_jump = taken;
            e_type = {ex_funct3_in[1], ex_funct3_in[2], ex_funct3_in[0]};
            m_b32  = sat_inc(m_b32, 64'hFFFF_FFFF);
            m_b4   = sat_inc(m_b4, 15);
            if (mis) begin
                m_m32      = sat_inc(m_m32, 64'hFFFF_FFFF);
                m_m4       = sat_inc(m_m4, 15);
                e_redirect = 1;
                e_rpc      = taken ? tgt : ex_pc_in + 64'd4;
            end
        end
        m_left  = nl;
        e_flush = (m_left > 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
        chk("redirect",    64'(redirect_out),    64'(e_redirect));
        chk("redirect_pc", redirect_pc_out,      e_rpc);
        chk("flush",       64'(flush_out),       64'(e_flush));
        chk("jump",        64'(jump_out),        64'(e_jump));
        chk("type",        64'(type_out),        64'(e_type));
        chk("update",      64'(upd_out),         64'(e_upd));
        chk("br_cnt",      64'(bcnt_out),        m_b32);
        chk("mis_cnt",     64'(mcnt_out),        m_m32);
        chk("s_redirect",  64'(s_redirect),      64'(e_redirect));
        chk("s_flush",     64'(s_flush),         64'(e_flush));
        chk("s_br_cnt",    64'(s_bcnt),          m_b4);
        chk("s_mis_cnt",   64'(s_mcnt),          m_m4);
    endtask

    task automatic br(input logic [2:0] f, input logic [63:0] pc, input logic [63:0] imm,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic pt, input logic [63:0] ptgt);
        ex_valid_in = 1; ex_is_branch_in = 1; ex_funct3_in = f;
        ex_pc_in = pc; ex_imm_in = imm; rs1_val_in = a; rs2_val_in = b;
        ex_pred_taken_in = pt; ex_pred_target_in = ptgt;
    endtask

    task automatic idle_in();
        ex_valid_in = 0; ex_is_branch_in = 0;
    endtask

    initial begin
        rst_in = 1; interrupt_signal_in = 0;
        br(3'd0, 0, 0, 0, 0, 0, 0);
        idle_in();
        tick(); tick();
        chk("reset_flush", 64'(flush_out), 64'd0);
        rst_in = 0;

        // correctly predicted taken BEQ
        br(3'd0, 64'h1000, 64'h40, 64'd5, 64'd5, 1, 64'h1040);
        tick();
        chk("tp1_upd", 64'(upd_out), 64'd1);
        chk("tp1_cnt", 64'(bcnt_out), 64'd1);
        idle_in(); tick();

        // BLT taken, predicted not-taken; wrong-path branches during flush
        br(3'd4, 64'h2000, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
        tick();
        chk("tp2_rpc", redirect_pc_out, 64'h2010);
        chk("tp2_flush", 64'(flush_out), 64'd1);
        br(3'd0, 64'h2010, 64'h8, 64'd1, 64'd1, 0, 0);
        tick();
        chk("tp2_ignored", 64'(upd_out), 64'd0);
        tick();
        chk("tp2_flush_end", 64'(flush_out), 64'd0);
        tick();
        chk("tp2_resolve", 64'(upd_out), 64'd1);
        idle_in(); tick(); tick(); tick();

        // BLTU not taken but predicted taken
        br(3'd6, 64'h3000, 64'h8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'h3008);
        tick();
        chk("tp3_rpc", redirect_pc_out, 64'h3004);
        idle_in(); tick(); tick();

        // BNE taken with wrong predicted target
        br(3'd1, 64'h4000, 64'h20, 64'd3, 64'd4, 1, 64'h5000);
        tick();
        chk("tp4_rpc", redirect_pc_out, 64'h4020);
        idle_in(); tick(); tick();

        // interrupt with a mispredicting branch, then interrupt during flush
        br(3'd1, 64'h6000, 64'h20, 64'd3, 64'd4, 0, 0);
        interrupt_signal_in = 1;
        tick();
        chk("irq_noredir", 64'(redirect_out), 64'd0);
        interrupt_signal_in = 0;
        tick();
        chk("irq_prev_flush_lead", 64'(flush_out), 64'd1);
        interrupt_signal_in = 1; idle_in();
        tick();
        chk("irq_flush_kill", 64'(flush_out), 64'd0);
        interrupt_signal_in = 0;
        tick();

        // saturation of the 4-bit counters: 20 mispredicts
        for (int i = 0; i < 20; i++) begin
            br(3'd0, 64'h7000, 64'h10, 64'd9, 64'd9, 0, 0);
            tick();
            idle_in(); tick(); tick();
        end
        chk("sat_mis4", 64'(s_mcnt), 64'd15);

        // reset mid-flush
        br(3'd5, 64'h8000, 64'h40, 64'd2, 64'd1, 0, 0);
        tick();
        idle_in(); rst_in = 1;
        tick();
        chk("rst_flush", 64'(flush_out), 64'd0);
        rst_in = 0;

        // random branches
        for (int i = 0; i < 600; i++) begin
            logic [63:0] a, b, pc, imm, tgt_ok;
            logic [12:0] ib;
            a  = {$urandom, $urandom};
            b  = ($urandom_range(3) == 0) ? a : {$urandom, $urandom};
            if ($urandom_range(3) == 0) begin a = 64'($urandom_range(7)); b = 64'($urandom_range(7)); end
            pc = {$urandom, $urandom} & ~64'h3;
            ib = 13'($urandom);
            imm = {{51{ib[12]}}, ib};
            tgt_ok = pc + imm;
            br(3'($urandom), pc, imm, a, b, 1'($urandom),
               ($urandom_range(1) == 0) ? tgt_ok : {$urandom, $urandom});
            ex_valid_in         = ($urandom_range(7) != 0);
            ex_is_branch_in     = ($urandom_range(7) != 0);
            interrupt_signal_in = ($urandom_range(15) == 0);
            rst_in              = ($urandom_range(99) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
